// File: rtl/pulse_edge_pkg.sv
// Shared types and constants for the multi-channel pulse edge generator.
package pulse_edge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2
  } state_e;

  localparam int unsigned DEF_DELAY_W = 10;
  localparam int unsigned DEF_WIDTH_W = 8;

  // Why a request was dropped; reserved for a future status readback path.
  typedef enum logic [0:0] {
    OVR_BUSY       = 1'b0,
    OVR_ZERO_WIDTH = 1'b1
  } ovr_reason_e;

endpackage

// File: rtl/pulse_edge_chan.sv
// One pulse channel: trigger-latched delay/width codes, countdown FSM and sticky overrun flag.
module pulse_edge_chan
  import pulse_edge_pkg::*;
#(
  parameter int unsigned DELAY_W = DEF_DELAY_W,
  parameter int unsigned WIDTH_W = DEF_WIDTH_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               trig_i,
  input  logic [DELAY_W-1:0] delay_code_i,
  input  logic [WIDTH_W-1:0] width_code_i,
  input  logic               cont_i,
  input  logic               ovr_clr_i,
  output logic               vout_o,
  output logic               busy_o,
  output logic               overrun_o
);

  state_e               state_q, state_d;
  logic [DELAY_W-1:0]   dcnt_q, dcnt_d;
  logic [WIDTH_W-1:0]   wcnt_q, wcnt_d;
  logic [DELAY_W-1:0]   dlat_q, dlat_d;
  logic [WIDTH_W-1:0]   wlat_q, wlat_d;
  logic                 ovr_q, ovr_d;

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    wcnt_d  = wcnt_q;
    dlat_d  = dlat_q;
    wlat_d  = wlat_q;
    ovr_d   = ovr_q & ~ovr_clr_i;

    unique case (state_q)
      ST_IDLE: begin
        if (trig_i) begin
          dlat_d = delay_code_i;
          wlat_d = width_code_i;
          if (width_code_i == '0) begin
            ovr_d = 1'b1;
          end else if (delay_code_i == '0) begin
            state_d = ST_PULSE;
            wcnt_d  = width_code_i;
          end else begin
            state_d = ST_DELAY;
            dcnt_d  = delay_code_i;
          end
        end
      end
      ST_DELAY: begin
        if (trig_i) ovr_d = 1'b1;
        if (dcnt_q == DELAY_W'(1)) begin
          state_d = ST_PULSE;
          wcnt_d  = wlat_q;
        end else begin
          dcnt_d = dcnt_q - DELAY_W'(1);
        end
      end
      ST_PULSE: begin
        // A trigger on the final pulse edge still sees the channel busy.
        if (trig_i) ovr_d = 1'b1;
        if (wcnt_q == WIDTH_W'(1)) begin
          if (!cont_i) begin
            state_d = ST_IDLE;
            wcnt_d  = '0;
          end else if (dlat_q == '0) begin
            wcnt_d = wlat_q;
          end else begin
            state_d = ST_DELAY;
            dcnt_d  = dlat_q;
          end
        end else begin
          wcnt_d = wcnt_q - WIDTH_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      dcnt_q  <= '0;
      wcnt_q  <= '0;
      dlat_q  <= '0;
      wlat_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      wcnt_q  <= wcnt_d;
      dlat_q  <= dlat_d;
      wlat_q  <= wlat_d;
      ovr_q   <= ovr_d;
    end
  end

  assign vout_o    = (state_q == ST_PULSE);
  assign busy_o    = (state_q != ST_IDLE);
  assign overrun_o = ovr_q;

endmodule

// File: rtl/pulse_edge_gen.sv
// Multi-channel programmable pulse generator: one independent pulse_edge_chan per output bit.
module pulse_edge_gen
  import pulse_edge_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DELAY_W  = DEF_DELAY_W,
  parameter int unsigned WIDTH_W  = DEF_WIDTH_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS-1:0]         trig,
  input  logic [CHANNELS*DELAY_W-1:0] delay_code,
  input  logic [CHANNELS*WIDTH_W-1:0] width_code,
  input  logic [CHANNELS-1:0]         cont,
  input  logic [CHANNELS-1:0]         ovr_clr,
  output logic [CHANNELS-1:0]         vout,
  output logic [CHANNELS-1:0]         busy,
  output logic [CHANNELS-1:0]         overrun
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    pulse_edge_chan #(
      .DELAY_W(DELAY_W),
      .WIDTH_W(WIDTH_W)
    ) u_chan (
      .clk_i       (clk),
      .rst_i       (rst),
      .trig_i      (trig[i]),
      .delay_code_i(delay_code[i*DELAY_W +: DELAY_W]),
      .width_code_i(width_code[i*WIDTH_W +: WIDTH_W]),
      .cont_i      (cont[i]),
      .ovr_clr_i   (ovr_clr[i]),
      .vout_o      (vout[i]),
      .busy_o      (busy[i]),
      .overrun_o   (overrun[i])
    );
  end

endmodule
